// File: rtl/machine_ram_ctrl.sv
// Word-addressed RAM controller: one request at a time, fixed wait states,
// registered status/read-data back to the CPU.
module machine_ram_ctrl #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        system1000,
   input  logic        system1000_rstn,
   input  logic [94:0] req,
   output logic [64:0] ramstatus
);

   // State encoding doubles as the status field, so status comes straight off a flop.
   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_ILLEGAL} op_t;

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   state_t                  state, next_state;
   logic [3:0]              wait_cnt;
   op_t                     cap_op;
   logic [29:0]             cap_addr;
   logic [31:0]             cap_wdata;
   logic [3:0]              cap_wmask;
   logic [31:0]             rdata;
   logic [29:0]             raddr;
   logic                    err;
   logic [31:0]             mem [DEPTH];

   op_t                     req_op;
   logic                    accept;
   logic                    complete;
   logic                    in_range;
   logic                    legal;
   logic                    do_write;
   logic [DEPTH_LOG2-1:0]   idx;
   logic                    unused_req;

   assign req_op     = op_t'(req[94:93]);
   assign unused_req = ^req[26:0];
   assign accept     = (state == IDLE) && (req_op != OP_NONE);
   assign complete   = (state == BUSY) && (wait_cnt == 4'd0);
   assign in_range   = (cap_addr >> DEPTH_LOG2) == 30'd0;
   assign legal      = in_range && (cap_op != OP_ILLEGAL);
   assign do_write   = complete && legal && (cap_op == OP_WRITE);
   assign idx        = cap_addr[DEPTH_LOG2-1:0];

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (req_op != OP_NONE) next_state = BUSY;
         BUSY:    if (wait_cnt == 4'd0)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         cap_op    <= OP_NONE;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_wmask <= '0;
         rdata     <= '0;
         raddr     <= '0;
         err       <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            cap_op    <= req_op;
            cap_addr  <= req[92:63];
            cap_wdata <= req[62:31];
            cap_wmask <= req[30:27];
            wait_cnt  <= 4'(WAIT_CYCLES);
         end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (complete) begin
            raddr <= cap_addr;
            err   <= !legal;
            rdata <= (legal && (cap_op == OP_READ)) ? mem[idx] : 32'd0;
         end
      end
   end

   // NOTE: the array has no reset; contents must survive reset and a RAM macro cannot be cleared.
   always_ff @(posedge system1000) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (cap_wmask[i]) mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
         end
      end
   end

   assign ramstatus = {state, rdata, raddr, err};

endmodule

// File: tb/tb_machine_ram_ctrl.sv
// Self-checking bench for machine_ram_ctrl: directed scenarios plus a randomized
// request stream checked against a word-array reference model.
module tb_machine_ram_ctrl;

   localparam int unsigned DEPTH_LOG2 = 10;
   localparam int unsigned WAIT       = 2;
   localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

   logic        system1000 = 1'b0;
   logic        system1000_rstn;
   logic [94:0] req;
   logic [64:0] ramstatus;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_mem   [DEPTH];
   bit          model_known [DEPTH];

   machine_ram_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT)) dut (
      .system1000      (system1000),
      .system1000_rstn (system1000_rstn),
      .req             (req),
      .ramstatus       (ramstatus)
   );

   always #5 system1000 = ~system1000;

   function automatic logic [94:0] mk_req(input logic [1:0] op, input logic [29:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] wmask);
      return {op, addr, wdata, wmask, 27'($urandom)};
   endfunction

   // Reference model: applies one request to the word array and predicts the completion.
   task automatic model_op(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, output logic [31:0] rd, output bit known,
                           output bit er);
      rd = 32'd0; known = 1'b1; er = 1'b0;
      if (op == 2'b11 || addr >= 30'(DEPTH)) begin
         er = 1'b1;
      end else if (op == 2'b10) begin
         for (int i = 0; i < 4; i++)
            if (wmask[i]) model_mem[addr][8*i +: 8] = wdata[8*i +: 8];
         model_known[addr] = model_known[addr] || (wmask == 4'hF);
      end else begin
         rd    = model_mem[addr];
         known = model_known[addr];
      end
   endtask

   // Expects acceptance at the next rising edge; samples 1 time unit after each edge.
   task automatic check_op(input string name, input logic [29:0] addr, input logic [31:0] exp_rd,
                           input bit rd_known, input bit exp_err, input bit drop,
                           input bit swap, input logic [94:0] swap_req);
      for (int k = 0; k <= int'(WAIT); k++) begin
         @(posedge system1000); #1;
         checks++;
         if (ramstatus[64:63] !== 2'b01) begin
            failures++;
            $display("FAIL %s busy[%0d]: status=%b expected=01", name, k, ramstatus[64:63]);
         end
         if (k == 0 && swap) req = swap_req;
      end
      for (int phase = 0; phase < 2; phase++) begin
         @(posedge system1000); #1;
         checks++;
         if (ramstatus[64:63] !== (phase == 0 ? 2'b10 : 2'b00)) begin
            failures++;
            $display("FAIL %s status phase%0d: got=%b expected=%b", name, phase,
                     ramstatus[64:63], (phase == 0 ? 2'b10 : 2'b00));
         end
         checks++;
         if (ramstatus[30:1] !== addr || ramstatus[0] !== exp_err) begin
            failures++;
            $display("FAIL %s raddr/err phase%0d: got=%0d/%b expected=%0d/%b", name, phase,
                     ramstatus[30:1], ramstatus[0], addr, exp_err);
         end
         if (rd_known) begin
            checks++;
            if (ramstatus[62:31] !== exp_rd) begin
               failures++;
               $display("FAIL %s rdata phase%0d: got=%h expected=%h", name, phase,
                        ramstatus[62:31], exp_rd);
            end
         end
         if (phase == 0 && drop) req = '0;
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [29:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
      logic [31:0] rd; bit known, er;
      @(negedge system1000);
      req = mk_req(op, addr, wdata, wmask);
      model_op(op, addr, wdata, wmask, rd, known, er);
      check_op(name, addr, rd, known, er, 1'b1, 1'b0, '0);
   endtask

   task automatic test_reset();
      logic [31:0] rd; bit known, er;
      system1000_rstn = 1'b0;
      req = mk_req(2'b01, 30'd5, 32'd0, 4'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge system1000);
         checks++;
         if (ramstatus !== 65'd0) begin
            failures++;
            $display("FAIL reset cycle%0d: ramstatus=%h expected=0", c, ramstatus);
         end
      end
      // Release with a write already present: first edge after release must accept it.
      system1000_rstn = 1'b1;
      req = mk_req(2'b10, 30'd5, 32'hDEADBEEF, 4'hF);
      model_op(2'b10, 30'd5, 32'hDEADBEEF, 4'hF, rd, known, er);
      check_op("write5_full", 30'd5, rd, known, er, 1'b1, 1'b0, '0);
   endtask

   task automatic test_rw_masks();
      run_op("read5_full",  2'b01, 30'd5, 32'd0, 4'h0);
      run_op("write5_0101", 2'b10, 30'd5, 32'h11223344, 4'b0101);
      run_op("read5_0101",  2'b01, 30'd5, 32'd0, 4'h0);
      checks++;
      if (model_mem[5] !== 32'hDE22BE44) begin
         failures++;
         $display("FAIL model_merge: got=%h expected=DE22BE44", model_mem[5]);
      end
      run_op("write5_mask0", 2'b10, 30'd5, 32'hFFFFFFFF, 4'h0);
      run_op("read5_mask0",  2'b01, 30'd5, 32'd0, 4'h0);
   endtask

   task automatic test_errors();
      run_op("read_oob",   2'b01, 30'd1024, 32'd0, 4'h0);
      run_op("illegal_op", 2'b11, 30'd0, 32'h12345678, 4'hF);
      run_op("write_oob",  2'b10, 30'h3FFF_FFFF, 32'hA5A5A5A5, 4'hF);
   endtask

   task automatic test_reset_abort();
      run_op("write7_zero", 2'b10, 30'd7, 32'd0, 4'hF);
      @(negedge system1000);
      req = mk_req(2'b10, 30'd7, 32'hCAFEF00D, 4'hF);
      for (int k = 0; k < 2; k++) begin
         @(posedge system1000); #1;
         checks++;
         if (ramstatus[64:63] !== 2'b01) begin
            failures++;
            $display("FAIL abort busy[%0d]: status=%b expected=01", k, ramstatus[64:63]);
         end
      end
      #2 system1000_rstn = 1'b0;
      #1;
      checks++;
      if (ramstatus !== 65'd0) begin
         failures++;
         $display("FAIL abort_reset: ramstatus=%h expected=0", ramstatus);
      end
      @(negedge system1000);
      req = '0;
      system1000_rstn = 1'b1;
      run_op("read7_after_abort", 2'b01, 30'd7, 32'd0, 4'h0);
   endtask

   task automatic test_prefill();
      for (int a = 0; a < 16; a++)
         run_op("prefill", 2'b10, 30'(a), $urandom, 4'hF);
   endtask

   task automatic test_busy_ignore();
      logic [31:0] rd; bit known, er;
      @(negedge system1000);
      req = mk_req(2'b10, 30'd3, 32'h0BADF00D, 4'hF);
      model_op(2'b10, 30'd3, 32'h0BADF00D, 4'hF, rd, known, er);
      check_op("write3_swapped", 30'd3, rd, known, er, 1'b0, 1'b1,
               mk_req(2'b01, 30'd9, 32'd0, 4'h0));
      model_op(2'b01, 30'd9, 32'd0, 4'h0, rd, known, er);
      check_op("read9_after_done", 30'd9, rd, known, er, 1'b1, 1'b0, '0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; bit known, er;
      @(negedge system1000);
      req = mk_req(2'b01, 30'd3, 32'd0, 4'h0);
      model_op(2'b01, 30'd3, 32'd0, 4'h0, rd, known, er);
      check_op("b2b_first", 30'd3, rd, known, er, 1'b0, 1'b0, '0);
      check_op("b2b_second", 30'd3, rd, known, er, 1'b1, 1'b0, '0);
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [29:0] addr;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0:       op = 2'b11;
            1, 2, 3: op = 2'b10;
            default: op = 2'b01;
         endcase
         if ($urandom_range(0, 7) == 0) addr = 30'(DEPTH) + 30'($urandom_range(0, 5000));
         else                           addr = 30'($urandom_range(0, 15));
         run_op("random", op, addr, $urandom, 4'($urandom));
      end
   endtask

   initial begin
      for (int a = 0; a < int'(DEPTH); a++) begin
         model_mem[a]   = 32'd0;
         model_known[a] = 1'b0;
      end
      test_reset();
      test_rw_masks();
      test_errors();
      test_reset_abort();
      test_prefill();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
